// File: rtl/morse_keyer_timing_if.sv
// rtl/morse_keyer_timing_if.sv - symbol stream handshake between keyer and decoder
interface morse_keyer_timing_if #(
  parameter int CW = 3
) ();
  logic          sym_valid;
  logic          sym_ready;
  logic [1:0]    sym_code;
  logic [CW-1:0] sym_count;

  modport master (output sym_valid, output sym_code, output sym_count, input sym_ready);
  modport slave  (input sym_valid, input sym_code, input sym_count, output sym_ready);
endinterface

// File: rtl/morse_keyer_timing.sv
// rtl/morse_keyer_timing.sv - debounced Morse key timing, symbol classifier and symbol FIFO
module morse_keyer_timing #(
  parameter int CLKS_PER_UNIT     = 50_000_000,
  parameter int DEBOUNCE_CLKS     = 500_000,
  parameter int DASH_UNITS        = 2,
  parameter int CHAR_GAP_UNITS    = 2,
  parameter int WORD_GAP_UNITS    = 4,
  parameter int TW                = 4,
  parameter int FIFO_DEPTH        = 4,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  button,
  morse_keyer_timing_if.master  sym,
  output logic                  pressed,
  output logic [TW-1:0]         t,
  output logic                  overflow
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DBW = $clog2(DEBOUNCE_CLKS + 1);
  localparam int PSW = $clog2(CLKS_PER_UNIT + 1);

  localparam logic [1:0] SYM_DOT   = 2'd0;
  localparam logic [1:0] SYM_DASH  = 2'd1;
  localparam logic [1:0] SYM_CHAR  = 2'd2;
  localparam logic [1:0] SYM_WORD  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

  logic [1:0]     sync_q;
  logic           key_lvl;
  logic [DBW-1:0] db_cnt;
  logic           key_edge;
  logic [PSW-1:0] presc;
  logic           unit_wrap;
  logic           tick;
  state_t         state;
  logic           push;
  logic [1:0]     push_code;
  logic [1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           fifo_valid;
  logic           full;
  logic           pop;
  logic           do_push;

  // Two-flop synchroniser; resets to the released level so no phantom press appears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {2{BUTTON_ACTIVE_LOW}};
    else        sync_q <= {sync_q[0], button};
  end

  assign key_lvl = sync_q[1] ^ BUTTON_ACTIVE_LOW;

  // Debounce: pressed toggles after DEBOUNCE_CLKS consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt   <= '0;
      pressed  <= 1'b0;
      key_edge <= 1'b0;
    end else begin
      key_edge <= 1'b0;
      if (key_lvl == pressed) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CLKS - 1)) begin
        db_cnt   <= '0;
        pressed  <= ~pressed;
        key_edge <= 1'b1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign unit_wrap = (presc == PSW'(CLKS_PER_UNIT - 1));
  assign tick      = unit_wrap && !key_edge;

  // Unit counter: prescaler free-runs, t saturates, both restart on a debounced edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      t     <= '0;
    end else if (key_edge) begin
      presc <= '0;
      t     <= '0;
    end else if (unit_wrap) begin
      presc <= '0;
      if (t != '1) t <= t + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Classifier FSM: turns press and gap durations into registered symbol pushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      push      <= 1'b0;
      push_code <= SYM_DOT;
    end else begin
      push <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_edge && pressed) state <= S_PRESS;
        end
        S_PRESS: begin
          if (key_edge) begin
            push      <= 1'b1;
            push_code <= (t < TW'(DASH_UNITS)) ? SYM_DOT : SYM_DASH;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (key_edge) begin
            state <= S_PRESS;
          end else if (tick && t == TW'(CHAR_GAP_UNITS - 1)) begin
            push      <= 1'b1;
            push_code <= SYM_CHAR;
          end else if (tick && t == TW'(WORD_GAP_UNITS - 1)) begin
            push      <= 1'b1;
            push_code <= SYM_WORD;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fifo_valid    = (count != '0);
  assign full          = (count == CW'(FIFO_DEPTH));
  assign pop           = fifo_valid && sym.sym_ready;
  assign do_push       = push && (!full || pop);
  assign sym.sym_valid = fifo_valid;
  assign sym.sym_code  = fifo_valid ? mem[rd_ptr] : 2'b00;
  assign sym.sym_count = count;

  // FIFO storage needs no reset; unread entries are masked by fifo_valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  // FIFO pointers, occupancy and sticky overflow on a dropped push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_morse_keyer_timing.sv
// tb/tb_morse_keyer_timing.sv - self-checking bench for morse_keyer_timing
module tb_morse_keyer_timing;
  localparam int CW = 3;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       button = 1'b1;
  logic       pressed;
  logic [3:0] t;
  logic       overflow;

  morse_keyer_timing_if #(.CW(CW)) sym_if ();

  morse_keyer_timing #(
    .CLKS_PER_UNIT(10), .DEBOUNCE_CLKS(3), .DASH_UNITS(2), .CHAR_GAP_UNITS(2),
    .WORD_GAP_UNITS(4), .TW(4), .FIFO_DEPTH(4), .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .button(button), .sym(sym_if),
    .pressed(pressed), .t(t), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         p1;
    int         g1;
    int         p2;
    int         n;
    logic [11:0] codes;
  } vec_t;

  vec_t       vecs[9];
  logic [1:0] got_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Record every accepted symbol; the pop happens on the following rising edge
  always @(negedge clk) begin
    if (reset && sym_if.sym_valid && sym_if.sym_ready) got_q.push_back(sym_if.sym_code);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_syms(input string name, input int n, input logic [11:0] codes);
    check({name, " count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s sym%0d", name, i), (i < got_q.size()) ? {30'd0, got_q[i]} : 32'd99,
            {30'd0, codes[2*i +: 2]});
    end
    got_q.delete();
  endtask

  initial begin
    sym_if.sym_ready = 1'b1;
    vecs[0] = '{15, 0,  0,  3, {6'd0, 2'd3, 2'd2, 2'd0}};
    vecs[1] = '{25, 0,  0,  3, {6'd0, 2'd3, 2'd2, 2'd1}};
    vecs[2] = '{20, 0,  0,  3, {6'd0, 2'd3, 2'd2, 2'd0}};
    vecs[3] = '{21, 0,  0,  3, {6'd0, 2'd3, 2'd2, 2'd1}};
    vecs[4] = '{15, 20, 15, 4, {4'd0, 2'd3, 2'd2, 2'd0, 2'd0}};
    vecs[5] = '{15, 21, 15, 5, {2'd0, 2'd3, 2'd2, 2'd0, 2'd2, 2'd0}};
    vecs[6] = '{25, 25, 15, 5, {2'd0, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1}};
    vecs[7] = '{15, 40, 15, 5, {2'd0, 2'd3, 2'd2, 2'd0, 2'd2, 2'd0}};
    vecs[8] = '{15, 41, 15, 6, {2'd3, 2'd2, 2'd0, 2'd3, 2'd2, 2'd0}};

    #1 reset = 1'b0;
    #2;
    check("rst pressed", pressed, 0);
    check("rst t", t, 0);
    check("rst valid", sym_if.sym_valid, 0);
    check("rst count", sym_if.sym_count, 0);
    check("rst code", sym_if.sym_code, 0);
    check("rst overflow", overflow, 0);
    #9 reset = 1'b1;

    // Idle key: t saturates, a short glitch must neither press nor clear t
    step(200);
    check("idle t sat", t, 15);
    begin
      int hi = 0;
      button = 1'b0;
      step(2);
      button = 1'b1;
      repeat (12) begin
        step(1);
        if (pressed) hi = 1;
      end
      check("glitch pressed", hi, 0);
    end
    check("glitch t", t, 15);
    check("glitch syms", got_q.size(), 0);

    // Debounce latency and t restart after the press edge
    button = 1'b0;
    step(4);
    check("lat pressed early", pressed, 0);
    step(1);
    check("lat pressed", pressed, 1);
    check("lat t before clear", t, 15);
    step(1);
    check("lat t cleared", t, 0);
    step(9);
    button = 1'b1;
    step(70);
    check_syms("lat", 3, {6'd0, 2'd3, 2'd2, 2'd0});

    for (int i = 0; i < 9; i++) begin
      button = 1'b0;
      step(vecs[i].p1);
      button = 1'b1;
      if (vecs[i].p2 != 0) begin
        step(vecs[i].g1);
        button = 1'b0;
        step(vecs[i].p2);
        button = 1'b1;
      end
      step(70);
      check_syms($sformatf("vec%0d", i), vecs[i].n, vecs[i].codes);
    end

    // Overflow: five dots into a stalled four-entry FIFO
    sym_if.sym_ready = 1'b0;
    repeat (5) begin
      button = 1'b0;
      step(15);
      button = 1'b1;
      step(10);
    end
    step(60);
    check("ovf count", sym_if.sym_count, 4);
    check("ovf flag", overflow, 1);
    check("ovf valid", sym_if.sym_valid, 1);
    check("ovf no pop", got_q.size(), 0);
    sym_if.sym_ready = 1'b1;
    step(10);
    check_syms("drain", 4, 12'd0);
    check("drain valid", sym_if.sym_valid, 0);
    check("drain count", sym_if.sym_count, 0);
    check("drain ovf sticky", overflow, 1);

    // Reset mid-press with a queued symbol, then re-detection of the held key
    sym_if.sym_ready = 1'b0;
    button = 1'b0;
    step(15);
    button = 1'b1;
    step(15);
    button = 1'b0;
    step(20);
    check("pre-rst pressed", pressed, 1);
    check("pre-rst count", sym_if.sym_count, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid-rst pressed", pressed, 0);
    check("mid-rst t", t, 0);
    check("mid-rst valid", sym_if.sym_valid, 0);
    check("mid-rst count", sym_if.sym_count, 0);
    check("mid-rst overflow", overflow, 0);
    #1 reset = 1'b1;
    sym_if.sym_ready = 1'b1;
    step(4);
    check("re-press early", pressed, 0);
    step(1);
    check("re-press", pressed, 1);
    step(10);
    button = 1'b1;
    step(70);
    check_syms("re-press", 3, {6'd0, 2'd3, 2'd2, 2'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
